// File: rtl/mips_pkg.sv
// Shared definitions for the TP4 MIPS pipeline: access sizes, MEM-stage FSM
// encodings and the MEM/WB register layout.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int WB_REGF_WR = 0;

  typedef struct packed {
    logic [4:0]  wb;
    logic        jl;
    logic [31:0] pc;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  wreg;
  } mem_wb_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for the MEM stage: store replication, byte
// enables, load extraction/extension and the alignment check.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    byte_lane    = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        if (is_store_i) begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        load_data_o = {{24{byte_lane[7] & ~is_unsigned_i}}, byte_lane};
      end
      SZ_HALF: begin
        misaligned_o = addr_lo_i[0];
        if (is_store_i) begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{store_data_i[15:0]}};
        end
        load_data_o = {{16{half_lane[15] & ~is_unsigned_i}}, half_lane};
      end
      default: misaligned_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the TP4 MIPS pipeline: data-memory req/ack access FSM with
// timeout, upstream stall, debug freeze and the MEM/WB pipeline register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_debug,
  input  logic [4:0]        in_wb,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic              in_jl,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_wreg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_stall,
  output logic              out_misaligned,
  output logic              out_bus_error,
  output logic [4:0]        out_wb,
  output logic              out_jl,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_mem_data,
  output logic [31:0]       out_alu_result,
  output logic [4:0]        out_wreg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_wb_t           mw_q, mw_d;
  mem_wb_t           hold_q, hold_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_pend_q, ack_pend_d;
  logic [31:0]       rdata_pend_q, rdata_pend_d;
  logic              misal_q, misal_d;
  logic              berr_q, berr_d;

  logic        in_idle, mem_op, ack_eff;
  logic [1:0]  al_lo, al_size;
  logic        al_uns, al_store, al_misal;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load, al_rdata;
  mem_wb_t     in_ent;

  assign in_idle  = (st_q == ST_IDLE);
  assign mem_op   = in_mem_read | in_mem_write;
  assign ack_eff  = dmem_ack | ack_pend_q;
  assign al_rdata = ack_pend_q ? rdata_pend_q : dmem_rdata;

  // In IDLE the aligner looks at the incoming op; afterwards at the captured one.
  assign al_lo    = in_idle ? in_alu_result[1:0] : hold_q.alu_result[1:0];
  assign al_size  = in_idle ? in_mem_size        : size_q;
  assign al_uns   = in_idle ? in_mem_unsigned    : uns_q;
  assign al_store = in_idle ? in_mem_write       : we_q;

  mem_lane_align u_align (
    .addr_lo_i     (al_lo),
    .size_i        (al_size),
    .is_unsigned_i (al_uns),
    .is_store_i    (al_store),
    .store_data_i  (in_store_data),
    .rdata_i       (al_rdata),
    .be_o          (al_be),
    .wdata_o       (al_wdata),
    .load_data_o   (al_load),
    .misaligned_o  (al_misal)
  );

  always_comb begin
    in_ent            = '0;
    in_ent.wb         = in_wb;
    in_ent.jl         = in_jl;
    in_ent.pc         = in_pc;
    in_ent.alu_result = in_alu_result;
    in_ent.wreg       = in_wreg;
  end

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    mw_d         = mw_q;
    hold_d       = hold_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    ack_pend_d   = ack_pend_q;
    rdata_pend_d = rdata_pend_q;
    misal_d      = misal_q;
    berr_d       = berr_q;
    if (stop_debug) begin
      if (st_q == ST_ACCESS && dmem_ack && !ack_pend_q) begin
        ack_pend_d   = 1'b1;
        rdata_pend_d = dmem_rdata;
      end
    end else begin
      misal_d = 1'b0;
      berr_d  = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (!mem_op) begin
            mw_d = in_ent;
          end else if (al_misal) begin
            misal_d = 1'b1;
            mw_d    = '0;
          end else begin
            st_d    = ST_ACCESS;
            cnt_d   = '0;
            mw_d    = '0;
            hold_d  = in_ent;
            we_d    = in_mem_write;
            size_d  = in_mem_size;
            uns_d   = in_mem_unsigned;
            be_d    = al_be;
            wdata_d = al_wdata;
            addr_d  = in_alu_result[ADDR_W+1:2];
          end
        end
        ST_ACCESS: begin
          mw_d = '0;
          if (ack_eff) begin
            st_d          = ST_DONE;
            ack_pend_d    = 1'b0;
            mw_d          = hold_q;
            mw_d.mem_data = we_q ? 32'd0 : al_load;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            st_d   = ST_DONE;
            cnt_d  = '0;
            berr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // The upstream op is still presented here; it was already serviced.
          st_d  = ST_IDLE;
          cnt_d = '0;
          mw_d  = '0;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(negedge clk) begin
    if (!rst) begin
      st_q         <= ST_IDLE;
      cnt_q        <= '0;
      mw_q         <= '0;
      hold_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      ack_pend_q   <= 1'b0;
      rdata_pend_q <= '0;
      misal_q      <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      mw_q         <= mw_d;
      hold_q       <= hold_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      ack_pend_q   <= ack_pend_d;
      rdata_pend_q <= rdata_pend_d;
      misal_q      <= misal_d;
      berr_q       <= berr_d;
    end
  end

  assign dmem_req       = (st_q == ST_ACCESS);
  assign dmem_we        = dmem_req & we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign out_stall      = rst & ((st_q == ST_ACCESS) | (in_idle & mem_op & ~al_misal));
  assign out_misaligned = misal_q;
  assign out_bus_error  = berr_q;
  assign out_wb         = mw_q.wb;
  assign out_jl         = mw_q.jl;
  assign out_pc         = mw_q.pc;
  assign out_mem_data   = mw_q.mem_data;
  assign out_alu_result = mw_q.alu_result;
  assign out_wreg       = mw_q.wreg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the DUT updates on the
// falling edge, so inputs are driven and outputs sampled away from it.
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_debug;
  logic [4:0]  in_wb;
  logic        in_mem_read, in_mem_write, in_mem_unsigned, in_jl;
  logic [1:0]  in_mem_size;
  logic [31:0] in_pc, in_alu_result, in_store_data;
  logic [4:0]  in_wreg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        out_stall, out_misaligned, out_bus_error, out_jl;
  logic [4:0]  out_wb, out_wreg;
  logic [31:0] out_pc, out_mem_data, out_alu_result;

  int n_checks = 0;
  int n_pass   = 0;

  int          stalls, reqs;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic [9:0]  seen_addr;
  logic        seen_we;

  mem_access_stage #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .stop_debug(stop_debug),
    .in_wb(in_wb), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
    .in_jl(in_jl), .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_wreg(in_wreg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .out_stall(out_stall), .out_misaligned(out_misaligned),
    .out_bus_error(out_bus_error), .out_wb(out_wb), .out_jl(out_jl),
    .out_pc(out_pc), .out_mem_data(out_mem_data),
    .out_alu_result(out_alu_result), .out_wreg(out_wreg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_nop();
    in_wb = '0; in_mem_read = 0; in_mem_write = 0; in_mem_size = SZ_WORD;
    in_mem_unsigned = 0; in_jl = 0; in_pc = '0; in_alu_result = '0;
    in_store_data = '0; in_wreg = '0; dmem_ack = 0;
  endtask

  // Presents one op and runs it until the stall drops; returns in the cycle
  // after the op's outcome was registered (DONE for an access).
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int ack_at);
    bit ended = 0;
    in_mem_read = rd; in_mem_write = wr; in_mem_size = sz; in_mem_unsigned = uns;
    in_alu_result = addr; in_store_data = sdata; dmem_rdata = rdata;
    stalls = 0; reqs = 0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (out_stall) stalls++;
      if (dmem_req) begin
        reqs++;
        if (reqs == 1) begin
          seen_be = dmem_be; seen_wdata = dmem_wdata;
          seen_addr = dmem_addr; seen_we = dmem_we;
        end
      end
      if (c > 0 && !out_stall) begin
        ended = 1;
        break;
      end
      dmem_ack = dmem_req && (reqs == ack_at);
      tick();
    end
    dmem_ack = 0;
    if (!ended) check("op_bound", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 0; stop_debug = 0; dmem_rdata = '0;
    set_nop();
    tick(); tick();
    check("rst_wb", 32'(out_wb), 32'd0);
    check("rst_alu", out_alu_result, 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(out_stall), 32'd0);
    check("rst_flags", {30'd0, out_misaligned, out_bus_error}, 32'd0);
    rst = 1;
    tick();

    // ALU op: one-cycle pass-through, never stalls
    in_wb = 5'b00001; in_wreg = 5'd3; in_jl = 1; in_pc = 32'h0000_0100;
    run_op(0, 0, SZ_WORD, 0, 32'h0000_0010, '0, '0, 0);
    check("alu_result", out_alu_result, 32'h0000_0010);
    check("alu_wb", 32'(out_wb), 32'd1);
    check("alu_wreg", 32'(out_wreg), 32'd3);
    check("alu_link", {out_jl, out_pc[30:0]}, 32'h8000_0100);
    check("alu_memdata", out_mem_data, 32'd0);
    check("alu_stalls", 32'(stalls), 32'd0);
    set_nop(); tick();

    // SB at 0x13, ack in the second access cycle
    run_op(0, 1, SZ_BYTE, 0, 32'h0000_0013, 32'h0000_00A5, '0, 2);
    check("sb_be", 32'(seen_be), 32'h8);
    check("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
    check("sb_addr", 32'(seen_addr), 32'h4);
    check("sb_we", 32'(seen_we), 32'd1);
    check("sb_stalls", 32'(stalls), 32'd3);
    check("sb_req_done", 32'(dmem_req), 32'd0);
    check("sb_memdata", out_mem_data, 32'd0);
    set_nop(); tick();

    // SH at 0x22 with zero-wait ack
    run_op(0, 1, SZ_HALF, 0, 32'h0000_0022, 32'h1234_ABCD, '0, 1);
    check("sh_be", 32'(seen_be), 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_stalls", 32'(stalls), 32'd2);
    set_nop(); tick();

    // LB signed / unsigned at 0x12
    in_wb = 5'b00001; in_wreg = 5'd5;
    run_op(1, 0, SZ_BYTE, 0, 32'h0000_0012, '0, 32'h0080_0000, 1);
    check("lb_be", 32'(seen_be), 32'hF);
    check("lb_we", 32'(seen_we), 32'd0);
    check("lb_data", out_mem_data, 32'hFFFF_FF80);
    check("lb_wb", 32'(out_wb), 32'd1);
    check("lb_wreg", 32'(out_wreg), 32'd5);
    set_nop(); tick();
    in_wb = 5'b00001; in_wreg = 5'd5;
    run_op(1, 0, SZ_BYTE, 1, 32'h0000_0012, '0, 32'h0080_0000, 3);
    check("lbu_data", out_mem_data, 32'h0000_0080);
    set_nop(); tick();

    // LH upper lane, signed
    in_wb = 5'b00001;
    run_op(1, 0, SZ_HALF, 0, 32'h0000_0022, '0, 32'h8001_0000, 1);
    check("lh_data", out_mem_data, 32'hFFFF_8001);
    set_nop(); tick();

    // Misaligned LW at 0x06
    in_wb = 5'b00001; in_wreg = 5'd9;
    run_op(1, 0, SZ_WORD, 0, 32'h0000_0006, '0, '0, 1);
    check("mis_reqs", 32'(reqs), 32'd0);
    check("mis_pulse", 32'(out_misaligned), 32'd1);
    check("mis_wb", 32'(out_wb), 32'd0);
    set_nop(); tick();
    check("mis_pulse_end", 32'(out_misaligned), 32'd0);

    // LW with no ack: timeout after 15 request cycles
    in_wb = 5'b00001;
    run_op(1, 0, SZ_WORD, 0, 32'h0000_0020, '0, '0, 0);
    check("to_reqs", 32'(reqs), 32'd15);
    check("to_berr", 32'(out_bus_error), 32'd1);
    check("to_wb", 32'(out_wb), 32'd0);
    check("to_stall", 32'(out_stall), 32'd0);
    set_nop(); tick();
    check("to_berr_end", 32'(out_bus_error), 32'd0);

    // Reset in the middle of an access
    in_wb = 5'b00001; in_mem_read = 1; in_mem_size = SZ_WORD; in_alu_result = 32'h40;
    #1; tick();
    check("rm_req_before", 32'(dmem_req), 32'd1);
    rst = 0; tick();
    check("rm_req", 32'(dmem_req), 32'd0);
    check("rm_stall", 32'(out_stall), 32'd0);
    check("rm_wb", 32'(out_wb), 32'd0);
    set_nop(); rst = 1; tick();
    check("rm_no_wb", 32'(out_wb), 32'd0);

    // stop_debug freeze with an ack latched during the freeze
    in_wb = 5'b00001; in_wreg = 5'd7; in_mem_read = 1; in_mem_size = SZ_WORD;
    in_alu_result = 32'h24; dmem_rdata = 32'h1234_5678;
    #1; tick();
    stop_debug = 1; tick();
    dmem_ack = 1; tick();
    dmem_ack = 0; dmem_rdata = 32'hDEAD_BEEF; #1;
    check("dbg_req", 32'(dmem_req), 32'd1);
    check("dbg_addr", 32'(dmem_addr), 32'h9);
    check("dbg_wb_hold", 32'(out_wb), 32'd0);
    tick();
    check("dbg_req_hold", 32'(dmem_req), 32'd1);
    stop_debug = 0; tick();
    check("dbg_data", out_mem_data, 32'h1234_5678);
    check("dbg_wb", 32'(out_wb), 32'd1);
    check("dbg_wreg", 32'(out_wreg), 32'd7);
    check("dbg_req_done", 32'(dmem_req), 32'd0);
    set_nop(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
